// File: rtl/envelope_detector.sv
// Recovers the applied envelope level (in eighths of the note's initial peak)
// from an enveloped sample stream by comparing per-window peak magnitudes.
module envelope_detector #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WINDOW_LOG2  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    note_start,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [3:0]              level,
  output logic                    level_valid,
  output logic [SAMPLE_WIDTH-1:0] ref_peak,
  output logic                    note_done
);

  localparam int PW = SAMPLE_WIDTH + 4;

  typedef enum logic [1:0] {IDLE, CAPTURE, TRACK, DONE} state_t;

  state_t                  state, state_next;
  logic [WINDOW_LOG2-1:0]  win_cnt, win_cnt_next;
  logic [SAMPLE_WIDTH-1:0] win_peak, win_peak_next;
  logic [SAMPLE_WIDTH-1:0] ref_peak_next;
  logic [3:0]              level_next;
  logic                    level_valid_next;
  logic                    note_done_next;
  logic [SAMPLE_WIDTH-1:0] mag;
  logic [SAMPLE_WIDTH-1:0] peak_incl;
  logic [PW-1:0]           scaled_peak;
  logic [3:0]              track_level;

  // Most negative input has no positive counterpart, so it saturates.
  always_comb begin
    mag = sample;
    if (sample[SAMPLE_WIDTH-1]) begin
      if (sample == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}})
        mag = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
      else
        mag = -sample;
    end
  end

  // The window-closing sample must take part in that window's evaluation.
  assign peak_incl = (mag > win_peak) ? mag : win_peak;

  // Largest k with 8*peak >= k*ref, found by comparison instead of division.
  always_comb begin
    track_level = 4'd0;
    scaled_peak = PW'(peak_incl) << 3;
    for (int k = 1; k <= 8; k++) begin
      if (scaled_peak >= PW'(k) * PW'(ref_peak))
        track_level = 4'(k);
    end
  end

  always_comb begin
    state_next       = state;
    win_cnt_next     = win_cnt;
    win_peak_next    = win_peak;
    ref_peak_next    = ref_peak;
    level_next       = level;
    level_valid_next = 1'b0;
    note_done_next   = note_done;
    if (note_start) begin
      state_next     = CAPTURE;
      win_cnt_next   = sample_valid ? WINDOW_LOG2'(1) : '0;
      win_peak_next  = sample_valid ? mag : '0;
      ref_peak_next  = '0;
      level_next     = 4'd0;
      note_done_next = 1'b0;
    end else begin
      case (state)
        CAPTURE, TRACK: begin
          if (sample_valid) begin
            win_cnt_next  = win_cnt + 1'b1;
            win_peak_next = peak_incl;
            if (win_cnt == '1) begin
              win_cnt_next  = '0;
              win_peak_next = '0;
              if (state == CAPTURE) begin
                if (peak_incl != '0) begin
                  ref_peak_next    = peak_incl;
                  level_next       = 4'd8;
                  level_valid_next = 1'b1;
                  state_next       = TRACK;
                end
              end else begin
                level_next       = track_level;
                level_valid_next = 1'b1;
                if (track_level == 4'd0) begin
                  note_done_next = 1'b1;
                  state_next     = DONE;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      win_cnt     <= '0;
      win_peak    <= '0;
      ref_peak    <= '0;
      level       <= 4'd0;
      level_valid <= 1'b0;
      note_done   <= 1'b0;
    end else begin
      state       <= state_next;
      win_cnt     <= win_cnt_next;
      win_peak    <= win_peak_next;
      ref_peak    <= ref_peak_next;
      level       <= level_next;
      level_valid <= level_valid_next;
      note_done   <= note_done_next;
    end
  end

endmodule

// File: tb/tb_envelope_detector.sv
// Bench for envelope_detector: directed test-plan walk followed by randomized
// notes, every cycle compared against a window-queue reference model.
module tb_envelope_detector;

  localparam int SW  = 16;
  localparam int WL  = 2;
  localparam int WIN = 1 << WL;

  logic          clk = 1'b0;
  logic          reset;
  logic          note_start;
  logic          sample_valid;
  logic [SW-1:0] sample;
  logic [3:0]    level;
  logic          level_valid;
  logic [SW-1:0] ref_peak;
  logic          note_done;

  always #5 clk = ~clk;

  envelope_detector #(.SAMPLE_WIDTH(SW), .WINDOW_LOG2(WL)) dut (
    .clk(clk), .reset(reset), .note_start(note_start),
    .sample_valid(sample_valid), .sample(sample), .level(level),
    .level_valid(level_valid), .ref_peak(ref_peak), .note_done(note_done)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    lv_seen  = 0;
  string phase    = "init";

  // Reference: mode 0 idle, 1 capture, 2 track, 3 done; window kept as a queue.
  int m_mode = 0;
  int m_win[$];
  int m_ref = 0, m_level = 0, m_lv = 0, m_done = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  function automatic int mag_of(logic [SW-1:0] s);
    int v;
    v = $signed(s);
    if (v == -(1 << (SW - 1))) return (1 << (SW - 1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step();
    int pk, lvl;
    m_lv = 0;
    if (!reset) begin
      m_mode = 0; m_win.delete(); m_ref = 0; m_level = 0; m_done = 0;
    end else if (note_start) begin
      m_mode = 1; m_win.delete(); m_ref = 0; m_level = 0; m_done = 0;
      if (sample_valid) m_win.push_back(mag_of(sample));
    end else if (sample_valid && (m_mode == 1 || m_mode == 2)) begin
      m_win.push_back(mag_of(sample));
      if (m_win.size() == WIN) begin
        pk = 0;
        foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
        m_win.delete();
        if (m_mode == 1) begin
          if (pk != 0) begin
            m_ref = pk; m_level = 8; m_lv = 1; m_mode = 2;
          end
        end else begin
          lvl = (8 * pk) / m_ref;
          if (lvl > 8) lvl = 8;
          m_level = lvl; m_lv = 1;
          if (lvl == 0) begin m_done = 1; m_mode = 3; end
        end
      end
    end
  endtask

  task automatic cycle(logic rst, logic ns, logic sv, int s);
    reset = rst; note_start = ns; sample_valid = sv; sample = SW'(s);
    @(posedge clk);
    model_step();
    #1;
    check("level", level, m_level);
    check("level_valid", level_valid, m_lv);
    check("ref_peak", ref_peak, m_ref);
    check("note_done", note_done, m_done);
    if (level_valid) lv_seen++;
  endtask

  task automatic strobes(int n, int s);
    repeat (n) cycle(1'b1, 1'b0, 1'b1, s);
  endtask

  initial begin
    int amp, m, r, nstb;

    phase = "reset";
    cycle(1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1234);
    check("rst_level", level, 0);
    check("rst_ref", ref_peak, 0);
    check("rst_done", note_done, 0);
    lv_seen = 0;
    strobes(8, 10400);
    check("idle_no_pulse", lv_seen, 0);
    check("idle_ref", ref_peak, 0);
    check("idle_level", level, 0);

    phase = "capture";
    cycle(1'b1, 1'b1, 1'b0, 0);
    lv_seen = 0;
    strobes(3, 10400);
    check("pre_close_lv", level_valid, 0);
    strobes(1, 10400);
    check("cap_ref", ref_peak, 10400);
    check("cap_level", level, 8);
    check("cap_lv", level_valid, 1);
    cycle(1'b1, 1'b0, 1'b0, 0);
    check("cap_lv_once", level_valid, 0);
    check("cap_pulses", lv_seen, 1);

    phase = "decay";
    strobes(4, 9100);
    check("lvl7", level, 7);
    strobes(4, -6500);
    check("lvl5", level, 5);
    strobes(4, 1300);
    check("lvl1", level, 1);
    check("lvl1_done", note_done, 0);
    strobes(4, 1299);
    check("lvl0", level, 0);
    check("lvl0_done", note_done, 1);
    lv_seen = 0;
    strobes(8, 5000);
    check("done_no_pulse", lv_seen, 0);
    check("done_hold", note_done, 1);

    phase = "saturate";
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("ns_clears_done", note_done, 0);
    lv_seen = 0;
    strobes(4, 0);
    check("silent_no_pulse", lv_seen, 0);
    check("silent_level", level, 0);
    strobes(4, -32768);
    check("sat_ref", ref_peak, 32767);
    check("sat_level", level, 8);

    phase = "restart";
    strobes(2, 3000);
    cycle(1'b1, 1'b1, 1'b1, 5000);
    check("rs_ref_clear", ref_peak, 0);
    check("rs_level_clear", level, 0);
    strobes(3, 4000);
    check("rs_ref", ref_peak, 5000);
    check("rs_level", level, 8);
    check("rs_lv", level_valid, 1);

    phase = "midreset";
    strobes(4, 4375);
    check("mr_lvl7", level, 7);
    strobes(2, 4375);
    cycle(1'b0, 1'b0, 1'b1, 4375);
    check("mr_level", level, 0);
    check("mr_ref", ref_peak, 0);
    check("mr_done", note_done, 0);
    check("mr_lv", level_valid, 0);
    lv_seen = 0;
    strobes(8, 10400);
    check("mr_ignore_pulse", lv_seen, 0);
    check("mr_ignore_ref", ref_peak, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);
    strobes(4, 700);
    check("mr_recapture", ref_peak, 700);

    phase = "random";
    for (int ep = 0; ep < 40; ep++) begin
      amp  = $urandom_range(1, 32767);
      nstb = 0;
      cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), amp);
      if (sample_valid) nstb++;
      for (int c = 0; c < 80; c++) begin
        r = $urandom_range(0, 99);
        if (r < 2) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), amp);
        else if (r < 4) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), amp);
        else if (r < 24) cycle(1'b1, 1'b0, 1'b0, $urandom_range(0, 65535));
        else if (r == 99) cycle(1'b1, 1'b0, 1'b1, -32768);
        else begin
          m = $urandom_range(0, amp);
          if ($urandom_range(0, 3) == 0) m = amp;
          cycle(1'b1, 1'b0, 1'b1, ($urandom_range(0, 1) == 1) ? m : -m);
          nstb++;
          if (nstb % WIN == 0) amp = (amp * $urandom_range(40, 95)) / 100;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
